inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  RV32I instruction encoder and program writer: the inverse of the core's immediate generator/decoder.
//  Accepts decoded fields (format, regs, funct, signed imm) over valid/ready and packs them into 32-bit words.
//  Writes words sequentially into instruction memory from a base address; used by the self-test program loader.
// PARAMETERS
//  ADDR_W   32   width of base_addr / wr_addr / err_addr
//  NOP_WORD 32'h0000_0013   word written for unknown format or rejected immediate (addi x0,x0,0)
// PORTS
//  clk        in   1   clock; all state changes on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   begin a program at base_addr (honoured only in IDLE)
//  base_addr  in   32  first write address, sampled on accepted start
//  in_valid   in   1   field bundle valid
//  in_ready   out  1   encoder accepts bundle this cycle
//  in_fmt     in   3   format code (pkg enum): 0 R,1 I_ARITH,2 I_LOAD,3 S,4 B,5 J,6 I_JALR,7 reserved
//  in_rd/in_rs1/in_rs2  in  5 each   register indices (unused ones ignored)
//  in_funct3  in   3   funct3 (ignored for J)
//  in_funct7  in   7   funct7 (R only)
//  in_imm     in   32  signed byte-offset immediate (ignored for R)
//  in_last    in   1   bundle is final word of program
//  wr_en      out  1   instruction-memory write strobe (no backpressure)
//  wr_addr    out  32  write address
//  wr_data    out  32  encoded instruction
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse after last word written
//  err        out  1   sticky: some bundle was rejected since start
//  err_addr   out  32  address of first rejected word
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, wr_en, done, err, busy = 0; wr_addr, wr_data, err_addr, addr counter = 0.
//  FSM: IDLE -start-> RUN (addr<=base_addr, err<=0, err_addr<=0); RUN -accept with in_last-> DRAIN;
//   DRAIN (1 cycle, final write issued) -> DONE (done=1, 1 cycle) -> IDLE. start outside IDLE ignored.
//  in_ready = (state==RUN). Accept = in_valid && in_ready. No accept in IDLE even if start same cycle.
//  Latency 1: bundle accepted at edge N -> wr_en=1 with wr_addr/wr_data during cycle N+1; counter += 4 per accept.
//  Back-to-back accepts give one write per cycle; wr_en=0 in cycles following no accept.
//  Encoding (opcode fixed by fmt): R 0110011, I_ARITH 0010011, I_LOAD 0000011, S 0100011, B 1100011,
//   J 1101111, I_JALR 1100111. I: imm[11:0]->[31:20]. S: imm[11:5]->[31:25], imm[4:0]->[11:7].
//   B: imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7].
//   J: imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12]. Shamt passed in imm by caller.
//  fmt=7: wr_data=NOP_WORD always; counts as rejected only when IMM_CHECK_EN defined.
//  Reset mid-program: pending write dropped, FSM to IDLE, all outputs to reset values next cycle.
//  Address counter wraps modulo 2^32 silently.
// CONFIGURATION
//  IMM_CHECK_EN defined: range/alignment check — I,S signed 12-bit; B signed 13-bit with imm[0]=0;
//   J signed 21-bit with imm[0]=0. Failure or fmt=7 -> wr_data=NOP_WORD, err set, err_addr latched on first only.
//  IMM_CHECK_EN undefined: imm silently truncated to the format's bits; err and err_addr tied 0.
// STRUCTURE
//  Package inst_enc_pkg: fmt enum, opcode localparams, NOP_WORD, per-format imm width constants.
//  Sub-module inst_pack (combinational fields->word + range-ok flag); top holds FSM, counter, output regs.
// TESTING
//  B fmt, rs1=1, rs2=2, funct3=0, imm=-4 -> wr_data=32'hFE20_8EE3 one cycle after accept.
//  J fmt, rd=1, imm=8 -> 32'h0080_00EF; I_ARITH rd=5, rs1=0, imm=-1 -> 32'hFFF0_0293.
//  start, base=0x100, 3 back-to-back bundles (last on 3rd) -> writes at 0x100/0x104/0x108, done pulse next cycle, in_ready 0 after last.
//  IMM_CHECK_EN: I_ARITH imm=2048 at 2nd word (base 0) -> wr_data=0x13, err=1, err_addr=0x4; later bad word leaves err_addr 0x4.
//  rst asserted the cycle after an accept -> no wr_en, busy=0, in_ready=0; new start resumes at new base.
//  Random round-trip: 10k bundles, extract imm from wr_data per format -> equals in_imm for all in-range values.

Source files
------------

// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder: format codes,
// opcodes, the NOP filler word and per-format immediate widths.
package inst_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I_ARITH = 3'd1,
    FMT_I_LOAD  = 3'd2,
    FMT_S       = 3'd3,
    FMT_B       = 3'd4,
    FMT_J       = 3'd5,
    FMT_I_JALR  = 3'd6,
    FMT_RSVD    = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I_ARITH = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S       = 7'b0100011;
  localparam logic [6:0] OP_B       = 7'b1100011;
  localparam logic [6:0] OP_J       = 7'b1101111;
  localparam logic [6:0] OP_I_JALR  = 7'b1100111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam int unsigned IMM_W_I = 12;
  localparam int unsigned IMM_W_S = 12;
  localparam int unsigned IMM_W_B = 13;
  localparam int unsigned IMM_W_J = 21;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
    logic [31:0] s;
    s = $unsigned($signed(v) >>> (n - 1));
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational field-to-word packer with an immediate range/alignment flag.
// Optional feature macro: IMM_CHECK_EN (out-of-range immediates replaced by the NOP word).
module inst_pack
  import inst_enc_pkg::*;
#(
  parameter logic [31:0] P_NOP = NOP_WORD
) (
  input  fmt_e        i_fmt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_ok
);

  logic [31:0] w_raw;
  logic        w_ok;

  always_comb begin
    w_raw = P_NOP;
    w_ok  = 1'b0;
    case (i_fmt)
      FMT_R: begin
        w_raw = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
        w_ok  = 1'b1;
      end
      FMT_I_ARITH: begin
        w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I_ARITH};
        w_ok  = fits_signed(i_imm, IMM_W_I);
      end
      FMT_I_LOAD: begin
        w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I_LOAD};
        w_ok  = fits_signed(i_imm, IMM_W_I);
      end
      FMT_I_JALR: begin
        w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I_JALR};
        w_ok  = fits_signed(i_imm, IMM_W_I);
      end
      FMT_S: begin
        w_raw = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_S};
        w_ok  = fits_signed(i_imm, IMM_W_S);
      end
      FMT_B: begin
        w_raw = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                 i_imm[4:1], i_imm[11], OP_B};
        w_ok  = fits_signed(i_imm, IMM_W_B) && !i_imm[0];
      end
      FMT_J: begin
        // funct3 and rs fields are not part of the J layout.
        w_raw = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_J};
        w_ok  = fits_signed(i_imm, IMM_W_J) && !i_imm[0];
      end
      default: begin
        w_raw = P_NOP;
        w_ok  = 1'b0;
      end
    endcase
  end

`ifdef IMM_CHECK_EN
  assign o_word = w_ok ? w_raw : P_NOP;
`else
  assign o_word = w_raw;
`endif
  assign o_ok = w_ok;

endmodule

// File: rtl/inst_encoder.sv
// RV32I program writer: accepts field bundles, packs them and writes words sequentially.
// Optional feature macro: IMM_CHECK_EN (rejected bundles raise sticky err / err_addr).
module inst_encoder #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = inst_enc_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  import inst_enc_pkg::*;

  // state    | meaning
  // ST_IDLE  | waiting for start
  // ST_RUN   | accepting bundles, one write per accept
  // ST_DRAIN | final write on the bus
  // ST_DONE  | done pulse, then back to idle
  state_e r_state, w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_wr_en;
  logic [31:0]       w_word;
  logic              w_ok;
  logic              w_accept;
  logic              w_start;

  assign w_accept = in_valid && (r_state == ST_RUN);
  assign w_start  = start && (r_state == ST_IDLE);

  inst_pack #(.P_NOP(NOP_WORD)) u_pack (
    .i_fmt    (fmt_e'(in_fmt)),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_imm    (in_imm),
    .o_word   (w_word),
    .o_ok     (w_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RUN;
      ST_RUN:   if (w_accept && in_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_start) begin
        r_addr <= base_addr;
      end else if (w_accept) begin
        r_addr    <= r_addr + ADDR_W'(4);
        r_wr_addr <= r_addr;
        r_wr_data <= w_word;
      end
    end
  end

`ifdef IMM_CHECK_EN
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;

  // Only the first rejected word of a program records its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_start) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_accept && !w_ok) begin
      r_err <= 1'b1;
      if (!r_err) r_err_addr <= r_addr;
    end
  end

  assign err      = r_err;
  assign err_addr = r_err_addr;
`else
  logic w_unused_ok;
  assign w_unused_ok = w_ok;
  assign err         = 1'b0;
  assign err_addr    = '0;
`endif

  assign in_ready = (r_state == ST_RUN);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed and random round-trip bench for inst_encoder; builds with or without IMM_CHECK_EN.
`timescale 1ns/1ps
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        in_last;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data;
  logic        busy, done, err;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  inst_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic last);
    in_valid  = 1'b1;
    in_fmt    = f;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    in_last   = last;
  endtask

  task automatic idle_in;
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic start_prog(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    tick();
    start     = 1'b0;
  endtask

  // Single-word program; returns write strobe/data of the accept cycle and the done flag two cycles later.
  task automatic run_one(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm, output logic we, output logic [31:0] data,
                         output logic dn);
    start_prog(32'h1000);
    drive(f, rd, rs1, rs2, f3, f7, imm, 1'b1);
    tick();
    we   = wr_en;
    data = wr_data;
    idle_in();
    tick();
    dn = done;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_in();
    base_addr = 32'hDEAD_BEE0;
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    start = 1'b1;
    tick(); tick();
    checks++;
    if ({in_ready, wr_en, done, err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready/wr_en/done/err/busy=%b expected 00000",
               {in_ready, wr_en, done, err, busy});
    end
    checks++;
    if (wr_addr !== 32'h0 || wr_data !== 32'h0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: got wr_addr=%h wr_data=%h err_addr=%h expected all 0",
               wr_addr, wr_data, err_addr);
    end
    rst = 1'b0;
    idle_in();
    tick();
  endtask

  task automatic test_encodings;
    logic [2:0]  f   [9];
    logic [4:0]  rd  [9];
    logic [4:0]  rs1 [9];
    logic [4:0]  rs2 [9];
    logic [2:0]  f3  [9];
    logic [6:0]  f7  [9];
    logic [31:0] imm [9];
    logic [31:0] exp [9];
    logic        we, dn;
    logic [31:0] data;
    // B beq x1,x2,-4 / J jal x1,8 / addi x5,x0,-1 / add / sub / sw x2,8(x1) / lw x5,-4(x1) / ret / reserved
    f[0]=3'd4; rd[0]=5'd0; rs1[0]=5'd1; rs2[0]=5'd2; f3[0]=3'd0; f7[0]=7'd0;  imm[0]=32'hFFFF_FFFC; exp[0]=32'hFE20_8EE3;
    f[1]=3'd5; rd[1]=5'd1; rs1[1]=5'd7; rs2[1]=5'd9; f3[1]=3'd5; f7[1]=7'd0;  imm[1]=32'd8;          exp[1]=32'h0080_00EF;
    f[2]=3'd1; rd[2]=5'd5; rs1[2]=5'd0; rs2[2]=5'd0; f3[2]=3'd0; f7[2]=7'd0;  imm[2]=32'hFFFF_FFFF; exp[2]=32'hFFF0_0293;
    f[3]=3'd0; rd[3]=5'd3; rs1[3]=5'd1; rs2[3]=5'd2; f3[3]=3'd0; f7[3]=7'h00; imm[3]=32'h1234_5678; exp[3]=32'h0020_81B3;
    f[4]=3'd0; rd[4]=5'd3; rs1[4]=5'd1; rs2[4]=5'd2; f3[4]=3'd0; f7[4]=7'h20; imm[4]=32'd0;          exp[4]=32'h4020_81B3;
    f[5]=3'd3; rd[5]=5'd0; rs1[5]=5'd1; rs2[5]=5'd2; f3[5]=3'd2; f7[5]=7'd0;  imm[5]=32'd8;          exp[5]=32'h0020_A423;
    f[6]=3'd2; rd[6]=5'd5; rs1[6]=5'd1; rs2[6]=5'd0; f3[6]=3'd2; f7[6]=7'd0;  imm[6]=32'hFFFF_FFFC; exp[6]=32'hFFC0_A283;
    f[7]=3'd6; rd[7]=5'd0; rs1[7]=5'd1; rs2[7]=5'd0; f3[7]=3'd0; f7[7]=7'd0;  imm[7]=32'd0;          exp[7]=32'h0000_8067;
    f[8]=3'd7; rd[8]=5'd3; rs1[8]=5'd1; rs2[8]=5'd2; f3[8]=3'd1; f7[8]=7'd1;  imm[8]=32'd4;          exp[8]=32'h0000_0013;
    for (int i = 0; i < 9; i++) begin
      run_one(f[i], rd[i], rs1[i], rs2[i], f3[i], f7[i], imm[i], we, data, dn);
      checks++;
      if (we !== 1'b1 || data !== exp[i]) begin
        errors++;
        $display("FAIL encode[%0d]: got wr_en=%b wr_data=%h expected wr_en=1 wr_data=%h",
                 i, we, data, exp[i]);
      end
      checks++;
      if (dn !== 1'b1) begin
        errors++;
        $display("FAIL encode_done[%0d]: got done=%b expected 1", i, dn);
      end
    end
  endtask

  task automatic test_back_to_back;
    start     = 1'b1;
    base_addr = 32'h100;
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    start = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_idle_accept: got wr_en=%b in_ready=%b expected 0/1", wr_en, in_ready);
    end
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h100 || wr_data !== 32'h0050_0093) begin
      errors++;
      $display("FAIL b2b_w0: got en=%b addr=%h data=%h expected 1/00000100/00500093",
               wr_en, wr_addr, wr_data);
    end
    start     = 1'b1;
    base_addr = 32'h800;
    drive(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
    tick();
    start = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h104 || wr_data !== 32'h0020_81B3) begin
      errors++;
      $display("FAIL b2b_w1: got en=%b addr=%h data=%h expected 1/00000104/002081b3",
               wr_en, wr_addr, wr_data);
    end
    drive(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1);
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h108 || wr_data !== 32'h0020_A423 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_w2: got en=%b addr=%h data=%h ready=%b done=%b expected 1/00000108/0020a423/0/0",
               wr_en, wr_addr, wr_data, in_ready, done);
    end
    idle_in();
    tick();
    checks++;
    if (done !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got done=%b wr_en=%b busy=%b expected 1/0/1", done, wr_en, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_gap;
    start_prog(32'h20);
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    idle_in();
    tick();
    checks++;
    if (wr_en !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL gap_no_write: got wr_en=%b in_ready=%b expected 0/1", wr_en, in_ready);
    end
    drive(3'd6, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h24 || wr_data !== 32'h0000_8067) begin
      errors++;
      $display("FAIL gap_w1: got en=%b addr=%h data=%h expected 1/00000024/00008067",
               wr_en, wr_addr, wr_data);
    end
    idle_in();
    tick(); tick();
  endtask

  task automatic test_wrap;
    start_prog(32'hFFFF_FFFC);
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    checks++;
    if (wr_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_w0: got addr=%h expected fffffffc", wr_addr);
    end
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_w1: got en=%b addr=%h expected 1/00000000", wr_en, wr_addr);
    end
    idle_in();
    tick(); tick();
  endtask

  task automatic test_imm_check;
    logic [31:0] exp_w1, exp_w2, exp_ea;
    logic        exp_err;
`ifdef IMM_CHECK_EN
    exp_w1 = 32'h0000_0013; exp_w2 = 32'h0000_0013; exp_err = 1'b1; exp_ea = 32'h4;
`else
    exp_w1 = 32'h8000_0293; exp_w2 = 32'h0000_0163; exp_err = 1'b0; exp_ea = 32'h0;
`endif
    start_prog(32'h0);
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    checks++;
    if (err !== 1'b0 || wr_data !== 32'h0050_0093) begin
      errors++;
      $display("FAIL imm_w0: got err=%b data=%h expected 0/00500093", err, wr_data);
    end
    drive(3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
    tick();
    checks++;
    if (wr_data !== exp_w1 || err !== exp_err || err_addr !== exp_ea) begin
      errors++;
      $display("FAIL imm_w1: got data=%h err=%b err_addr=%h expected %h/%b/%h",
               wr_data, err, err_addr, exp_w1, exp_err, exp_ea);
    end
    drive(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0);
    tick();
    checks++;
    if (wr_data !== exp_w2 || err !== exp_err || err_addr !== exp_ea) begin
      errors++;
      $display("FAIL imm_w2: got data=%h err=%b err_addr=%h expected %h/%b/%h",
               wr_data, err, err_addr, exp_w2, exp_err, exp_ea);
    end
    drive(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
    tick();
    idle_in();
    tick(); tick();
    checks++;
    if (wr_data !== 32'h13 || err !== exp_err || err_addr !== exp_ea) begin
      errors++;
      $display("FAIL imm_sticky: got data=%h err=%b err_addr=%h expected 00000013/%b/%h",
               wr_data, err, err_addr, exp_err, exp_ea);
    end
    start_prog(32'h40);
    checks++;
    if (err !== 1'b0 || err_addr !== 32'h0) begin
      errors++;
      $display("FAIL imm_clear: got err=%b err_addr=%h expected 0/00000000", err, err_addr);
    end
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    idle_in();
    tick(); tick();
  endtask

  task automatic test_reset_mid;
    start_prog(32'h40);
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h40) begin
      errors++;
      $display("FAIL rstmid_pre: got en=%b addr=%h expected 1/00000040", wr_en, wr_addr);
    end
    drive(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b0);
    rst = 1'b1;
    tick();
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_post: got en=%b busy=%b ready=%b addr=%h data=%h expected 0/0/0/0/0",
               wr_en, busy, in_ready, wr_addr, wr_data);
    end
    rst = 1'b0;
    idle_in();
    tick();
    start_prog(32'h200);
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
    tick();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 32'h200 || wr_data !== 32'h0050_0093) begin
      errors++;
      $display("FAIL rstmid_resume: got en=%b addr=%h data=%h expected 1/00000200/00500093",
               wr_en, wr_addr, wr_data);
    end
    idle_in();
    tick(); tick();
  endtask

  task automatic test_round_trip;
    localparam int N = 10000;
    logic [2:0]  fcode [6];
    logic [2:0]  f;
    logic [31:0] imm, got, w;
    int          sel;
    fcode[0]=3'd1; fcode[1]=3'd2; fcode[2]=3'd3; fcode[3]=3'd4; fcode[4]=3'd5; fcode[5]=3'd6;
    start_prog(32'h0);
    for (int i = 0; i < N; i++) begin
      sel = int'($urandom_range(5));
      f   = fcode[sel];
      case (f)
        3'd4:    imm = 32'((int'($urandom_range(4095)) - 2048) * 2);
        3'd5:    imm = 32'((int'($urandom_range(1048575)) - 524288) * 2);
        default: imm = 32'(int'($urandom_range(4095)) - 2048);
      endcase
      drive(f, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
            imm, i == N - 1);
      tick();
      w = wr_data;
      case (f)
        3'd3:    got = {{20{w[31]}}, w[31:25], w[11:7]};
        3'd4:    got = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        3'd5:    got = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        default: got = {{20{w[31]}}, w[31:20]};
      endcase
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 32'(i * 4) || got !== imm) begin
        errors++;
        $display("FAIL roundtrip[%0d] fmt=%0d: got en=%b addr=%h imm=%h expected 1/%h/%h",
                 i, f, wr_en, wr_addr, got, 32'(i * 4), imm);
      end
    end
    idle_in();
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL roundtrip_done: got done=%b expected 1", done);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    base_addr = '0;
    in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    test_reset();
    test_encodings();
    test_back_to_back();
    test_gap();
    test_wrap();
    test_imm_check();
    test_reset_mid();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
